// File: rtl/waveform_packetizer.sv
// Frames each trigger-window snapshot into a sync/seq/height/samples/checksum byte packet over valid/ready.
// Optional PACKET_TIMESTAMP_EN inserts a 4-byte cycle timestamp after the sequence byte.
module waveform_packetizer #(
  parameter int          NSAMP    = 32,
  parameter int          SAMPLE_W = 14,
  parameter logic [7:0]  SYNC0    = 8'hA5,
  parameter logic [7:0]  SYNC1    = 8'h5A
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        long_trigger,
  input  logic [31:0]                 pulse_height,
  input  logic [NSAMP*SAMPLE_W-1:0]   waveform_flat,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic [7:0]                  drop_count
);

`ifdef PACKET_TIMESTAMP_EN
  localparam int TSB = 4;
`else
  localparam int TSB = 0;
`endif
  localparam int PH0   = 3 + TSB;
  localparam int SAMP0 = 5 + TSB;
  localparam int PLEN  = SAMP0 + 2*NSAMP + 1;
  localparam int IW    = $clog2(PLEN);
  localparam int KW    = (NSAMP > 1) ? $clog2(NSAMP) : 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                      r_state;
  logic                        r_trig_d;
  logic [NSAMP*SAMPLE_W-1:0]   r_snap;
  logic [15:0]                 r_ph;
  logic [7:0]                  r_seq;
  logic [IW-1:0]               r_idx;
  logic [7:0]                  r_csum;
  logic [7:0]                  r_tx_data;
  logic                        r_tx_valid;
  logic                        r_busy;
  logic [7:0]                  r_drop;
`ifdef PACKET_TIMESTAMP_EN
  logic [31:0]                 r_cyc;
  logic [31:0]                 r_ts;
`endif

  logic           w_event;
  logic           w_xfer;
  logic           w_last;
  logic [IW-1:0]  w_nidx;
  logic [IW-1:0]  w_rel;
  logic [KW-1:0]  w_k;
  logic [15:0]    w_samp16;
  logic [7:0]     w_csum_next;
  logic [7:0]     w_next_byte;

  assign w_event = r_trig_d & ~long_trigger;
  assign w_xfer  = r_tx_valid & tx_ready;
  assign w_last  = (r_idx == IW'(PLEN-1));

  // Next byte is built from the snapshot one cycle ahead so tx_data can be registered.
  always_comb begin
    w_nidx      = r_idx + IW'(1);
    w_rel       = w_nidx - IW'(SAMP0);
    w_k         = KW'(w_rel >> 1);
    w_samp16    = 16'(r_snap[w_k*SAMPLE_W +: SAMPLE_W]);
    w_csum_next = r_csum;
    if (r_idx >= IW'(2) && r_idx <= IW'(PLEN-2))
      w_csum_next = r_csum + r_tx_data;
    w_next_byte = 8'h00;
    if (w_nidx == IW'(1))
      w_next_byte = SYNC1;
    else if (w_nidx == IW'(2))
      w_next_byte = r_seq;
`ifdef PACKET_TIMESTAMP_EN
    else if (w_nidx < IW'(PH0))
      w_next_byte = r_ts[8*(PH0-1-int'(w_nidx)) +: 8];
`endif
    else if (w_nidx == IW'(PH0))
      w_next_byte = r_ph[15:8];
    else if (w_nidx == IW'(PH0+1))
      w_next_byte = r_ph[7:0];
    else if (w_nidx < IW'(PLEN-1))
      w_next_byte = w_rel[0] ? w_samp16[7:0] : w_samp16[15:8];
    else
      w_next_byte = w_csum_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_trig_d   <= 1'b0;
      r_snap     <= '0;
      r_ph       <= '0;
      r_seq      <= '0;
      r_idx      <= '0;
      r_csum     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= '0;
`ifdef PACKET_TIMESTAMP_EN
      r_cyc      <= '0;
      r_ts       <= '0;
`endif
    end else begin
      r_trig_d <= long_trigger;
`ifdef PACKET_TIMESTAMP_EN
      r_cyc    <= r_cyc + 32'd1;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_event) begin
            r_snap     <= waveform_flat;
            r_ph       <= (pulse_height > 32'h0000_FFFF) ? 16'hFFFF : pulse_height[15:0];
`ifdef PACKET_TIMESTAMP_EN
            r_ts       <= r_cyc;
`endif
            r_idx      <= '0;
            r_csum     <= '0;
            r_tx_data  <= SYNC0;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          // Events during a packet, even on its final transfer, are counted as lost.
          if (w_event && r_drop != 8'hFF)
            r_drop <= r_drop + 8'd1;
          if (w_xfer) begin
            r_csum <= w_csum_next;
            if (w_last) begin
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_seq      <= r_seq + 8'd1;
              r_state    <= S_IDLE;
            end else begin
              r_idx     <= w_nidx;
              r_tx_data <= w_next_byte;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign busy       = r_busy;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_waveform_packetizer.sv
// Directed bench for waveform_packetizer: table of packet vectors plus drop, saturation and reset sequences.
module tb_waveform_packetizer;
  localparam int NSAMP = 32;
  localparam int SW    = 14;
`ifdef PACKET_TIMESTAMP_EN
  localparam int TSB = 4;
`else
  localparam int TSB = 0;
`endif
  localparam int PH0   = 3 + TSB;
  localparam int SAMP0 = 5 + TSB;
  localparam int PLEN  = SAMP0 + 2*NSAMP + 1;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  long_trigger = 1'b0;
  logic [31:0]           pulse_height = '0;
  logic [NSAMP*SW-1:0]   waveform_flat = '0;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready = 1'b0;
  logic                  busy;
  logic [7:0]            drop_count;

  waveform_packetizer #(.NSAMP(NSAMP), .SAMPLE_W(SW), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
    .clk(clk), .reset_n(reset_n), .long_trigger(long_trigger), .pulse_height(pulse_height),
    .waveform_flat(waveform_flat), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  rx [PLEN];
  logic [7:0]  ex [PLEN];
  logic [13:0] wf [NSAMP];
  logic [7:0]  exp_seq;

  typedef struct {
    logic [31:0] ph;
    bit          sat;
    int          base;
    bit          stall;
    logic [7:0]  b_ph_hi, b_ph_lo, b_s0_hi, b_s0_lo, b_s31_lo, csum;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_wave(input bit sat, input int base);
    for (int k = 0; k < NSAMP; k++) begin
      wf[k] = sat ? 14'h3FFF : 14'(base + k);
      waveform_flat[k*SW +: SW] = wf[k];
    end
  endtask

  task automatic build_exp(input logic [31:0] ph);
    logic [15:0] p;
    logic [15:0] s;
    p = (ph > 32'h0000_FFFF) ? 16'hFFFF : ph[15:0];
    for (int i = 0; i < PLEN; i++) ex[i] = 8'h00;
    ex[0] = 8'hA5;
    ex[1] = 8'h5A;
    ex[2] = exp_seq;
    ex[PH0]   = p[15:8];
    ex[PH0+1] = p[7:0];
    for (int k = 0; k < NSAMP; k++) begin
      s = {2'b00, wf[k]};
      ex[SAMP0+2*k]   = s[15:8];
      ex[SAMP0+2*k+1] = s[7:0];
    end
  endtask

  task automatic compare_pkt();
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < PLEN-1; i++) begin
      if (i < 3 || i >= PH0) chk($sformatf("byte%0d", i), rx[i], ex[i]);
      if (i >= 2) sum = sum + rx[i];
    end
    chk("checksum_vs_stream", rx[PLEN-1], sum);
  endtask

  // Event on the edge after long_trigger falls; first byte is valid right after that edge.
  task automatic fire_event();
    tx_ready = 1'b0;
    @(posedge clk); #1 long_trigger = 1'b1;
    @(posedge clk); #1 long_trigger = 1'b0;
    @(negedge clk);
    chk("pre_event_valid", tx_valid, 1'b0);
    @(posedge clk); #1;
    chk("latency_valid", tx_valid, 1'b1);
    chk("latency_sync0", tx_data, 8'hA5);
    chk("latency_busy", busy, 1'b1);
  endtask

  task automatic run_packet(input bit stall, input int inject_at, input int reset_at);
    int         n;
    int         cyc;
    int         inj;
    bit         prev_stall;
    bit         did_reset;
    logic [7:0] prev_dat;
    n = 0; cyc = 0; inj = 0; prev_stall = 1'b0; did_reset = 1'b0; prev_dat = 8'h00;
    while (n < PLEN && cyc < 2000) begin
      @(posedge clk); #1;
      if (inj == 1) begin
        long_trigger = 1'b0;
        inj = 2;
      end
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("stall_valid_hold", tx_valid, 1'b1);
        chk("stall_data_hold", tx_data, prev_dat);
      end
      if (tx_valid && tx_ready) begin
        rx[n] = tx_data;
        n++;
        prev_stall = 1'b0;
        if (n == inject_at) begin
          long_trigger = 1'b1;
          pulse_height = 32'd7;
          set_wave(1'b0, 900);
          inj = 1;
        end
        if (n == reset_at) begin
          #2 reset_n = 1'b0;
          #1;
          chk("async_reset_valid", tx_valid, 1'b0);
          chk("async_reset_busy", busy, 1'b0);
          chk("async_reset_data", tx_data, 8'h00);
          did_reset = 1'b1;
          break;
        end
      end else begin
        prev_stall = tx_valid;
      end
      prev_dat = tx_data;
    end
    if (!did_reset) begin
      chk("packet_length", n, PLEN);
      @(posedge clk); #1;
      chk("busy_after_last", busy, 1'b0);
      chk("valid_after_last", tx_valid, 1'b0);
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    bit saw_valid;
    vt[0] = '{32'd500,        1'b0, 100, 1'b0, 8'h01, 8'hF4, 8'h00, 8'h64, 8'h83, 8'h65};
    vt[1] = '{32'd500,        1'b0, 100, 1'b1, 8'h01, 8'hF4, 8'h00, 8'h64, 8'h83, 8'h66};
    vt[2] = '{32'hFFFF_FFF0,  1'b1, 0,   1'b1, 8'hFF, 8'hFF, 8'h3F, 8'hFF, 8'hFF, 8'hC0};
    vt[3] = '{32'h0001_0000,  1'b0, 0,   1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h1F, 8'hF1};
    vt[4] = '{32'h0000_FFFF,  1'b0, 200, 1'b1, 8'hFF, 8'hFF, 8'h00, 8'hC8, 8'hE7, 8'hF2};

    #23;
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_drop_count", drop_count, 8'h00);
    reset_n = 1'b1;
    exp_seq = 8'h00;

    for (int v = 0; v < 5; v++) begin
      set_wave(vt[v].sat, vt[v].base);
      pulse_height = vt[v].ph;
      fire_event();
      build_exp(vt[v].ph);
      run_packet(vt[v].stall, -1, -1);
      compare_pkt();
      chk($sformatf("v%0d_ph_hi", v), rx[PH0], vt[v].b_ph_hi);
      chk($sformatf("v%0d_ph_lo", v), rx[PH0+1], vt[v].b_ph_lo);
      chk($sformatf("v%0d_s0_hi", v), rx[SAMP0], vt[v].b_s0_hi);
      chk($sformatf("v%0d_s0_lo", v), rx[SAMP0+1], vt[v].b_s0_lo);
      chk($sformatf("v%0d_s31_lo", v), rx[PLEN-2], vt[v].b_s31_lo);
`ifndef PACKET_TIMESTAMP_EN
      chk($sformatf("v%0d_csum", v), rx[PLEN-1], vt[v].csum);
`endif
      exp_seq = exp_seq + 8'd1;
    end

    // Second capture event during a packet, with the upstream inputs changing underneath.
    set_wave(1'b0, 100);
    pulse_height = 32'd500;
    fire_event();
    build_exp(32'd500);
    run_packet(1'b0, 20, -1);
    compare_pkt();
    exp_seq = exp_seq + 8'd1;
    chk("drop_after_one", drop_count, 8'd1);
    saw_valid = 1'b0;
    tx_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_valid) saw_valid = 1'b1;
    end
    tx_ready = 1'b0;
    chk("no_second_packet", saw_valid, 1'b0);

    // Many lost events while stalled: counter saturates.
    set_wave(1'b1, 0);
    pulse_height = 32'hFFFF_FFF0;
    fire_event();
    for (int e = 0; e < 300; e++) begin
      @(posedge clk); #1 long_trigger = 1'b1;
      @(posedge clk); #1 long_trigger = 1'b0;
    end
    @(posedge clk); #1;
    chk("drop_saturated", drop_count, 8'd255);
    chk("stalled_busy", busy, 1'b1);
    chk("stalled_sync0", tx_data, 8'hA5);
    build_exp(32'hFFFF_FFF0);
    run_packet(1'b1, -1, -1);
    compare_pkt();

    // Reset in the middle of a packet, then a fresh packet from sequence zero.
    set_wave(1'b0, 100);
    pulse_height = 32'd500;
    fire_event();
    run_packet(1'b0, -1, 40);
    chk("reset_drop_clear", drop_count, 8'h00);
    @(negedge clk) reset_n = 1'b1;
    exp_seq = 8'h00;
    fire_event();
    build_exp(32'd500);
    run_packet(1'b0, -1, -1);
    compare_pkt();
    chk("fresh_seq_zero", rx[2], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
